// File: rtl/uart_pkg.sv
// Shared UART definitions: frame format constants and bit-period arithmetic
// used by both the receiver and the transmitter.
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int uart_bit_cycles(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

  // Width of a counter that must hold values 0..bit_cycles.
  function automatic int uart_counter_width(input int bit_cycles);
    return $clog2(bit_cycles + 1);
  endfunction

endpackage

// File: rtl/uart_input_synchronizer.sv
// Multi-flop synchronizer for the asynchronous serial line. Resets to the
// idle level (1) so a reset never looks like a start bit.
module uart_input_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_p;

  // Shift the line through the synchronizer chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p <= '1;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_p[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8N1 (or more stop bits), mid-bit sampling, single-entry
// holding register with valid/ready hand-off, frame-error and overrun pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int BAUD_RATE       = 9600,
  parameter int CLOCK_FREQUENCY = 100000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      uart,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      frame_error,
  output logic                      overrun
);

  localparam int BIT_CYCLES  = uart_bit_cycles(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CNT_W       = uart_counter_width(BIT_CYCLES);
  localparam int IDX_W       = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t                    state, state_n;
  logic [CNT_W-1:0]          cnt, cnt_n;
  logic [IDX_W-1:0]          bit_idx, bit_idx_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic                      byte_done;
  logic                      frame_err_n;
  logic                      rx;

  uart_input_synchronizer #(
    .STAGES(2)
  ) u_sync (
    .clock   (clock),
    .reset   (reset),
    .async_in(uart),
    .sync_out(rx)
  );

  // Receiver state, bit timer, bit index and shift register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  // Frame sequencing: find the start bit, sample each bit at its centre,
  // check the stop bit; a low stop bit parks in WAIT_IDLE until the line rises.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt + CNT_W'(1);
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    byte_done   = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx == UART_START_BIT) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (rx == UART_START_BIT) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n            = '0;
          shift_n[bit_idx] = rx;
          bit_idx_n        = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_LAST) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx == UART_STOP_BIT) begin
            byte_done = 1'b1;
            state_n   = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx == UART_STOP_BIT) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Holding register hand-off: load when empty or being drained, otherwise
  // drop the new byte and flag an overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      data        <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= frame_err_n;
      overrun     <= 1'b0;
      if (byte_done && (!valid || ready)) begin
        data  <= shift;
        valid <= 1'b1;
      end else if (byte_done) begin
        overrun <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 10 MHz / 1 Mbaud (10 cycles per bit).
module tb_uart_receiver;

  localparam int CF  = 10000000;
  localparam int BR  = 1000000;
  localparam int BIT = CF / BR;

  logic       clock = 1'b0;
  logic       reset;
  logic       uart;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_error;
  logic       overrun;

  uart_receiver #(
    .BAUD_RATE(BR),
    .CLOCK_FREQUENCY(CF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .uart       (uart),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  always #50 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Observed activity.
  logic [7:0] got_q[$];
  int ferr_cnt, ovr_cnt, vcycles, first_valid_cyc;
  logic       prev_stall;
  logic [7:0] prev_data;

  // Reference model state.
  logic [7:0] exp_q[$];
  int exp_ferr, exp_ovr;
  logic       model_full;
  logic [7:0] model_held;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record transfers and pulses; while stalled, data/valid must not move.
  always @(negedge clock) begin
    if (!reset) begin
      if (valid && ready) got_q.push_back(data);
      if (valid) begin
        vcycles++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (frame_error) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (prev_stall) begin
        checks++;
        assert (valid === 1'b1 && data === prev_data) else begin
          errors++;
          $error("FAIL stall_hold: observed valid=%b data=%0h expected valid=1 data=%0h",
                 valid, data, prev_data);
        end
      end
      prev_stall = valid && !ready;
      prev_data  = data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_all();
    got_q.delete();
    exp_q.delete();
    ferr_cnt = 0;
    ovr_cnt = 0;
    vcycles = 0;
    first_valid_cyc = -1;
    exp_ferr = 0;
    exp_ovr = 0;
  endtask

  // Drive one frame; the model decides what the receiver must report.
  task automatic send_frame(input logic [7:0] b, input int stops, input logic stop_val);
    uart = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      uart = b[i];
      tick(BIT);
    end
    uart = stop_val;
    tick(BIT);
    if (stop_val) begin
      for (int s = 1; s < stops; s++) tick(BIT);
      if (ready) exp_q.push_back(b);
      else if (model_full) exp_ovr++;
      else begin
        model_full = 1'b1;
        model_held = b;
      end
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_data"}, got_q[i], exp_q[i]);
    check({tag, "_frame_error"}, ferr_cnt, exp_ferr);
    check({tag, "_overrun"}, ovr_cnt, exp_ovr);
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] b99;
    int         st;
    uart = 1'b1;
    ready = 1'b1;
    reset = 1'b1;
    model_full = 1'b0;
    prev_stall = 1'b0;
    prev_data = '0;
    clear_all();
    tick(3);
    check("reset_valid", valid, 0);
    check("reset_data", data, 0);
    check("reset_frame_error", frame_error, 0);
    check("reset_overrun", overrun, 0);
    reset = 1'b0;
    tick(5);

    // Single frame, latency and one-cycle valid.
    clear_all();
    st = cyc;
    send_frame(8'hA5, 1, 1'b1);
    tick(20);
    compare_all("a5");
    check("a5_latency", first_valid_cyc - st, 3 + BIT / 2 + 9 * BIT);
    check("a5_valid_cycles", vcycles, 1);

    // Back-to-back frames with two stop bits.
    clear_all();
    send_frame(8'h00, 2, 1'b1);
    send_frame(8'hFF, 2, 1'b1);
    send_frame(8'h3C, 2, 1'b1);
    tick(20);
    compare_all("b2b");
    check("b2b_valid_cycles", vcycles, 3);

    // Short low glitch is rejected.
    clear_all();
    uart = 1'b0;
    tick(3);
    uart = 1'b1;
    tick(30);
    check("glitch_valid_cycles", vcycles, 0);
    send_frame(8'h55, 1, 1'b1);
    tick(20);
    compare_all("glitch");

    // Bad stop bit followed by a break, then a good frame.
    clear_all();
    send_frame(8'h81, 1, 1'b0);
    tick(40);
    uart = 1'b1;
    tick(30);
    check("ferr_valid_cycles", vcycles, 0);
    send_frame(8'h42, 1, 1'b1);
    tick(20);
    compare_all("ferr");

    // Stalled consumer: second byte is dropped with an overrun.
    clear_all();
    ready = 1'b0;
    send_frame(8'h11, 1, 1'b1);
    send_frame(8'h22, 1, 1'b1);
    tick(20);
    check("stall_valid", valid, 1);
    check("stall_data", data, 8'h11);
    ready = 1'b1;
    if (model_full) exp_q.push_back(model_held);
    model_full = 1'b0;
    tick(20);
    compare_all("stall");

    // Reset during data bit 4 of 0x99; held until the line is idle.
    clear_all();
    b99 = 8'h99;
    uart = 1'b0;
    tick(BIT);
    for (int i = 0; i < 4; i++) begin
      uart = b99[i];
      tick(BIT);
    end
    uart = b99[4];
    tick(BIT / 2);
    reset = 1'b1;
    tick(BIT - BIT / 2);
    for (int i = 5; i < 8; i++) begin
      uart = b99[i];
      tick(BIT);
    end
    uart = 1'b1;
    tick(BIT + 20);
    reset = 1'b0;
    tick(10);
    check("rst_valid", valid, 0);
    send_frame(8'h6E, 1, 1'b1);
    tick(20);
    compare_all("rst");

    // Random bytes, stop-bit counts and idle gaps.
    clear_all();
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, int'($urandom_range(1, 3)), 1'b1);
      tick(int'($urandom_range(0, 15)));
    end
    tick(20);
    compare_all("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 9600, line bit rate in bits/s.
REQ-002 SHALL have parameter CLOCK_FREQUENCY, default 100000000, clock frequency in Hz.
REQ-003 SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port uart  input  1  asynchronous serial line; idles high.
REQ-006 SHALL have port data  output  8  received byte; valid only while valid=1.
REQ-007 SHALL have port valid  output  1  data holds an unconsumed byte.
REQ-008 SHALL have port ready  input  1  consumer accepts data when valid and ready are both 1 at a rising edge.
REQ-009 SHALL have port frame_error  output  1  one-cycle pulse when a frame's stop bit samples low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped because the holding register is occupied.

Function
REQ-011 SHALL define BIT_CYCLES = CLOCK_FREQUENCY/BAUD_RATE (integer division) and HALF_CYCLES = BIT_CYCLES/2; counter width = clog2(BIT_CYCLES+1).
REQ-012 SHALL pass uart through a 2-flop synchronizer; all decisions use the synchronized value rx; both flops reset to 1.
REQ-013 SHALL accept frames of 1 start bit (0), 8 data bits LSB first, and at least 1 stop bit (1); extra stop bits and idle time are absorbed in IDLE.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE: on rx=0 SHALL go to START with counter cleared.
REQ-016 START: counter SHALL increment each cycle; at counter = HALF_CYCLES-1, rx=0 -> DATA with counter and bit index cleared; rx=1 -> IDLE (glitch rejected, no output, no error).
REQ-017 DATA: at counter = BIT_CYCLES-1, SHALL sample rx into bit position bit_index, clear counter, and increment bit_index; after the sample for bit_index 7 -> STOP.
REQ-018 STOP: at counter = BIT_CYCLES-1, rx=1 -> byte complete, go to IDLE; rx=0 -> frame_error pulse, byte discarded, go to WAIT_IDLE.
REQ-019 WAIT_IDLE: SHALL remain until rx=1, then go to IDLE; no start detection while rx stays low (break condition).
REQ-020 Byte complete with valid=0, or with valid=1 and ready=1 in the same cycle: data SHALL load the new byte and valid SHALL be 1 on the next cycle.
REQ-021 Byte complete with valid=1 and ready=0: the new byte SHALL be dropped, data/valid SHALL be unchanged, and overrun SHALL pulse for one cycle.
REQ-022 valid=1 and ready=1 with no byte completing: valid SHALL be 0 next cycle; data SHALL hold its value.
REQ-023 Latency: valid SHALL rise on the cycle after the stop-bit sample edge.
REQ-024 data and valid SHALL not change while valid=1 and ready=0, except as stated in REQ-021, which leaves them unchanged.
REQ-025 The receiver SHALL not depend on ready to advance its state machine; reception continues while output is stalled.

Reset
REQ-026 On reset, state SHALL go to IDLE; counter, bit_index, shift register and data SHALL go to 0; valid, frame_error and overrun SHALL go to 0; synchronizer flops SHALL go to 1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no valid, frame_error or overrun output; after release, reception SHALL resume only on a new falling edge of rx.

Structure
REQ-028 Shared package uart_pkg SHALL hold UART_DATA_BITS=8, frame start/stop bit values, and the bit-period/counter-width calculation used by both uart_receiver and uart_transmitter.
REQ-029 State encoding SHALL be local to uart_receiver.
REQ-030 The synchronizer SHALL be a separate sub-module, uart_input_synchronizer: 2 stages, reset value 1.

Verification
Bench parameters: CLOCK_FREQUENCY=10000000, BAUD_RATE=1000000 (BIT_CYCLES=10); stimulus driven as exact 10-cycle bits; ready=1 unless stated otherwise.
REQ-031 Send frame for 0xA5 with 1 stop bit -> valid=1 with data=0xA5 for one cycle; frame_error=0; overrun=0.
REQ-032 Back-to-back frames 0x00, 0xFF, 0x3C, each with 2 stop bits -> three valid pulses in order with matching data; no errors.
REQ-033 Drive rx low for 3 cycles, then high -> no valid and no frame_error; a following 0x55 frame is received correctly.
REQ-034 Send frame for 0x81 with stop bit 0, hold the line low for 40 cycles, then high -> one frame_error pulse and no valid; a subsequent 0x42 frame is received.
REQ-035 ready=0; send 0x11 then 0x22 -> valid holds data=0x11; one overrun pulse at completion of 0x22; after ready=1, one transfer of 0x11 and no 0x22.
REQ-036 Assert reset at data bit 4 of 0x99, release it, then send 0x6E -> no output for 0x99; data=0x6E received.
